// File: rtl/sap_alu_pkg.sv
// Shared types and constants for the SAP-1 arithmetic unit.
package sap_alu_pkg;

    localparam int WIDTH_C     = 8;
    localparam int MUL_ITERS_C = 8;
    localparam int CNT_W_C     = $clog2(MUL_ITERS_C);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Add or subtract with the carry-out kept in the top bit.
    // Subtract is A + ~B + 1, so a carry-out of 1 means no borrow.
    function automatic logic [WIDTH_C:0] add_sub(
        input logic [WIDTH_C-1:0] a,
        input logic [WIDTH_C-1:0] b,
        input logic               su
    );
        logic [WIDTH_C-1:0] b_op;
        b_op = su ? ~b : b;
        return {1'b0, a} + {1'b0, b_op} + {{WIDTH_C{1'b0}}, su};
    endfunction

endpackage

// File: rtl/sap_alu_if.sv
// Operand, strobe and result bundle between the SAP-1 controller and the ALU.
interface sap_alu_if
    import sap_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             Su;
    logic             Lu_bar;
    logic             Mul_bar;
    logic             Eu;
    logic [WIDTH-1:0] data_out;
    logic             bus_oe;
    logic             cf;
    logic             zf;
    logic             busy;
    logic             done;

    // Controller side: drives operands and strobes, observes result and status.
    modport master (
        output a_in, b_in, Su, Lu_bar, Mul_bar, Eu,
        input  data_out, bus_oe, cf, zf, busy, done
    );

    // ALU side.
    modport slave (
        input  a_in, b_in, Su, Lu_bar, Mul_bar, Eu,
        output data_out, bus_oe, cf, zf, busy, done
    );
endinterface

// File: rtl/sap_shift_add_mul.sv
// Iterative unsigned shift-add multiplier; one partial product per step.
module sap_shift_add_mul
    import sap_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
) (
    input  logic               CLK,
    input  logic               CLR_bar,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] product_nxt,
    output logic               last_step
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] product;
    logic [CNT_W_C-1:0] count;

    // Product after the current step; the top latches this on the final step
    // so the last partial product lands in R on the same edge.
    always_comb begin
        product_nxt = mplier[0] ? (product + mcand) : product;
        last_step   = (count == CNT_W_C'(MUL_ITERS_C - 1));
    end

    // Operand capture on load, then shift multiplicand left and multiplier right per step.
    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            count   <= '0;
        end else if (load) begin
            mcand   <= {{WIDTH{1'b0}}, mcand_in};
            mplier  <= mplier_in;
            product <= '0;
            count   <= '0;
        end else if (step) begin
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            product <= product_nxt;
            count   <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sap_alu.sv
// SAP-1 registered ALU: single-cycle add/sub and 8-step multiply driving the W bus.
//
//   state | meaning
//   IDLE  | accepts latch (Lu_bar) and multiply (Mul_bar) commands
//   MUL   | multiplier iterating, busy high, strobes ignored
//   DONE  | result in R, done high for this one cycle, then IDLE
module sap_alu
    import sap_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
) (
    input  logic     CLK,
    input  logic     CLR_bar,
    sap_alu_if.slave alu
);

    state_t             state;
    logic [WIDTH-1:0]   r_q;
    logic               cf_q;
    logic               zf_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH:0]     sum;
    logic               mul_load;
    logic               mul_step;
    logic               mul_last;
    logic [2*WIDTH-1:0] prod_nxt;

    // Datapath decode: the adder result and multiplier control from current state.
    always_comb begin
        sum      = add_sub(alu.a_in, alu.b_in, alu.Su);
        mul_load = (state == IDLE) && !alu.Mul_bar;
        mul_step = (state == MUL);
    end

    sap_shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .CLK         (CLK),
        .CLR_bar     (CLR_bar),
        .load        (mul_load),
        .step        (mul_step),
        .mcand_in    (alu.a_in),
        .mplier_in   (alu.b_in),
        .product_nxt (prod_nxt),
        .last_step   (mul_last)
    );

    // Sequencer: owns R, the flags and the busy/done status registers.
    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            state  <= IDLE;
            r_q    <= '0;
            cf_q   <= 1'b0;
            zf_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Multiply wins over a simultaneous latch strobe.
                    if (!alu.Mul_bar) begin
                        state  <= MUL;
                        busy_q <= 1'b1;
                    end else if (!alu.Lu_bar) begin
                        r_q  <= sum[WIDTH-1:0];
                        cf_q <= sum[WIDTH];
                        zf_q <= (sum[WIDTH-1:0] == '0);
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        r_q    <= prod_nxt[WIDTH-1:0];
                        cf_q   <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
                        zf_q   <= (prod_nxt[WIDTH-1:0] == '0);
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Output drive; the bus enable is a straight pass of Eu.
    always_comb begin
        alu.data_out = r_q;
        alu.cf       = cf_q;
        alu.zf       = zf_q;
        alu.busy     = busy_q;
        alu.done     = done_q;
        alu.bus_oe   = alu.Eu;
    end

endmodule

// File: tb/tb_sap_alu.sv
// Scoreboard bench for sap_alu: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_sap_alu;

    logic CLK;
    logic CLR_bar;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        string      name;
        int         due;
        logic [7:0] r;
        logic       cf;
        logic       zf;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    sap_alu_if u_if ();

    sap_alu dut (
        .CLK     (CLK),
        .CLR_bar (CLR_bar),
        .alu     (u_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    // Monitor: compare the scoreboard head whose due cycle has arrived, flag stray done pulses.
    exp_t e;
    logic done_exp;
    always @(negedge CLK) begin
        if (CLR_bar) begin
            done_exp = 1'b0;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s: not sampled, due cycle %0d, now %0d", e.name, e.due, cyc);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                done_exp = e.done;
                n_tests++;
                if (u_if.data_out !== e.r || u_if.cf !== e.cf || u_if.zf !== e.zf ||
                    u_if.busy !== e.busy || u_if.done !== e.done) begin
                    n_fail++;
                    $display("FAIL %s: got R=%02h cf=%b zf=%b busy=%b done=%b, want R=%02h cf=%b zf=%b busy=%b done=%b",
                             e.name, u_if.data_out, u_if.cf, u_if.zf, u_if.busy, u_if.done,
                             e.r, e.cf, e.zf, e.busy, e.done);
                end
            end
            if (u_if.done === 1'b1 && !done_exp) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_done: got done=1 at cycle %0d, want 0", cyc);
            end
        end
    end

    task automatic expect_at(input string name, input int due, input logic [7:0] r,
                             input logic cf, input logic zf, input logic busy, input logic done);
        exp_t x;
        x.name = name; x.due = due; x.r = r; x.cf = cf; x.zf = zf; x.busy = busy; x.done = done;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called just after a posedge; strobes are held for exactly the next edge.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic su,
                      input logic lu_b, input logic mul_b, output int edge_n);
        u_if.a_in    = a;
        u_if.b_in    = b;
        u_if.Su      = su;
        u_if.Lu_bar  = lu_b;
        u_if.Mul_bar = mul_b;
        edge_n = cyc + 1;
        @(posedge CLK);
        #1;
        u_if.Lu_bar  = 1'b1;
        u_if.Mul_bar = 1'b1;
    endtask

    task automatic check_now(input string name, input logic [11:0] got, input logic [11:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %03h, want %03h", name, got, want);
        end
    endtask

    initial begin
        int e0;
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        CLR_bar = 1'b0;
        u_if.a_in    = 8'h00;
        u_if.b_in    = 8'h00;
        u_if.Su      = 1'b0;
        u_if.Lu_bar  = 1'b1;
        u_if.Mul_bar = 1'b1;
        u_if.Eu      = 1'b0;
        idle(2);
        check_now("reset_state", {u_if.data_out, u_if.cf, u_if.zf, u_if.busy, u_if.done}, 12'h000);
        CLR_bar = 1'b1;
        idle(1);

        // Add and subtract, one edge each
        op(8'h2A, 8'h10, 1'b0, 1'b0, 1'b1, e0);
        expect_at("add_2a_10", e0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.Eu = 1'b1;
        #1 check_now("bus_oe_hi", {11'h0, u_if.bus_oe}, 12'h001);
        u_if.Eu = 1'b0;
        #1 check_now("bus_oe_lo", {11'h0, u_if.bus_oe}, 12'h000);
        idle(1);
        op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, e0);
        expect_at("add_ff_01", e0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        op(8'h05, 8'h07, 1'b1, 1'b0, 1'b1, e0);
        expect_at("sub_05_07", e0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Multiply 0x0C * 0x0B = 0x84; R held until edge 8
        op(8'h0C, 8'h0B, 1'b0, 1'b1, 1'b0, e0);
        expect_at("mul1_busy_e1", e0 + 1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_at("mul1_hold_e7", e0 + 7, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_at("mul1_done_e8", e0 + 8, 8'h84, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at("mul1_idle_e9", e0 + 9, 8'h84, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(9);

        // Multiply 0x20 * 0x10 = 0x0200, operand changes and Lu_bar pulse mid-run
        op(8'h20, 8'h10, 1'b0, 1'b1, 1'b0, e0);
        expect_at("mul2_hold_e5", e0 + 5, 8'h84, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_at("mul2_done_e8", e0 + 8, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_at("mul2_idle_e9", e0 + 9, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        u_if.a_in   = 8'hFF;
        u_if.b_in   = 8'hFF;
        u_if.Lu_bar = 1'b0;
        idle(1);
        u_if.Lu_bar = 1'b1;
        idle(7);

        // Both strobes low: multiply wins (0x0C), not the sum 0x07
        op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, e0);
        expect_at("both_no_latch", e0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_at("both_mul_e8", e0 + 8, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(9);

        // Reset after iteration 4 aborts the multiply, no done pulse
        op(8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0, e0);
        idle(4);
        CLR_bar = 1'b0;
        #1 check_now("reset_mid_mul", {u_if.data_out, u_if.cf, u_if.zf, u_if.busy, u_if.done}, 12'h000);
        idle(2);
        CLR_bar = 1'b1;
        idle(1);
        op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, e0);
        expect_at("add_after_rst", e0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at("no_late_done", e0 + 6, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
